l1_trigger_scaler_rx: RTL and testbench
=======================================

# l1_trigger_scaler_rx

Receive end of the packed L1 trigger stream. The L1 trigger design packs its per-beam trigger bits into a 128-bit AXI4-Stream and sends it to the capture buffer and DAC outputs. This block consumes that stream, unpacks the trigger bits, and counts rising edges per beam over a fixed gate window. At the end of each window it latches a bank of per-beam scaler values for readout. It sits in the `aclk` domain next to the L1 trigger design and feeds the rate-monitoring / threshold-servo logic.

## Interface
Parameters:
- `NBEAMS`, 2: number of beams carried in the stream. Range 1..12.
- `COUNT_BITS`, 16: width of each scaler counter. Range 2..32.
- `GATE_LEN`, 1000: gate window length in `aclk` cycles. Must be ≥ 2.

Ports:
- `aclk`  in  1  stream and logic clock; the only clock.
- `reset_i`  in  1  synchronous, active-high reset.
- `trig_tdata`  in  128  packed stream. Eight 16-bit words; each word carries a 12-bit payload in bits [15:4], with bits [3:0] zero. Trigger bit b is `trig_tdata[4+b]`.
- `trig_tvalid`  in  1  beat valid.
- `trig_tready`  out  1  always 1 except while `reset_i` is high.
- `rd_sel_i`  in  $clog2(NBEAMS) (min 1)  beam index to read.
- `rd_data_o`  out  COUNT_BITS  latched scaler value for `rd_sel_i`.
- `rd_sat_o`  out  1  the selected beam saturated during the last gate.
- `update_o`  out  1  one-cycle pulse when a new scaler bank is latched.
- `gate_cnt_o`  out  $clog2(GATE_LEN)  current position in the gate window (debug).

## Operation
- **Beat acceptance.** A beat is accepted when `trig_tvalid && trig_tready`.
  - Only words 0 bits [4 +: NBEAMS] are used.
  - All other payload bits are ignored.
- **Edge detection, per beam b.**
  - `rise[b] = accepted && trig[b] && !prev[b]`.
  - `prev[b]` updates only on accepted beats.
  - Non-accepted cycles neither count nor change `prev`.
- **Counting.** Counter `cnt[b]` increments by 1 on `rise[b]`.
  - Saturates at 2^COUNT_BITS−1.
  - When an increment is attempted at the maximum, `sat[b]` is set. It stays set until the next latch.
- **Gate counter.**
  - Free-running from 0 to GATE_LEN−1, then wraps to 0.
  - Counts every `aclk` cycle, independent of `trig_tvalid`.
- **Latch, on the cycle where the gate counter equals GATE_LEN−1:**
  - `bank[b] <= sat_add(cnt[b], rise[b])`. A rise on the final cycle counts in the closing window.
  - `bank_sat[b] <= sat[b]`, or'ed with saturation occurring on this cycle.
  - `cnt[b] <= 0` and `sat[b] <= 0`.
  - `update_o <= 1` on the next cycle only.
- **Readout.** `rd_data_o` and `rd_sat_o` are registered: `bank[rd_sel_i]` and `bank_sat[rd_sel_i]` from the previous cycle.
  - An out-of-range `rd_sel_i` returns 0 / 0.
- **Reset.**
  - `cnt`, `sat`, `bank`, `bank_sat`, gate counter, `update_o`, `rd_data_o`, `rd_sat_o` and `gate_cnt_o` all go to 0.
  - `trig_tready` is 0 while reset is high.
  - `prev` resets to all-ones, so a trigger level held through reset does not count as an edge.
  - Reset mid-gate discards the partial window; no latch and no `update_o` pulse are produced.

## Timing
- **Stream to count:**
  - A rise on an accepted beat in cycle N is reflected in `cnt` at cycle N+1.
  - The first `update_o` after reset release falls at cycle GATE_LEN (counting the first non-reset cycle as 0). Subsequent pulses follow every GATE_LEN cycles.
- **Bank visibility.** The bank is valid in the same cycle `update_o` is high.
  - `rd_data_o` shows the new value one cycle after that, for a fixed `rd_sel_i`.
- **Readout latency.** `rd_sel_i` to `rd_data_o` is 1 cycle.
- **Back-to-back edges.** A 1,0,1 pattern on consecutive accepted beats gives 2 counts. A beam held at 1 across any number of beats gives 1 count.
- **Throughput.** 1 beat per cycle; there is no backpressure beyond reset.

## Test plan
- **Single pulses.** NBEAMS=2, GATE_LEN=1000, tvalid=1 continuously. Beam 0 is high for 1 beat at cycles 10, 20 and 30; beam 1 stays idle.
  - Required: `update_o` at cycle 1000; `rd_sel_i`=0 reads 3; `rd_sel_i`=1 reads 0; both `rd_sat_o`=0.
- **Level held through reset.** Beam 0 is held at 1 through reset and for 500 cycles after it.
  - Required: bank[0]=0.
  - A second test with beam 0 held from cycle 100 to 600 gives bank[0]=1.
- **tvalid gaps.** Beam 1 toggles every cycle, but tvalid=1 only on even cycles, and the trigger value on odd cycles disagrees.
  - Required: count equals the number of 0→1 transitions seen on accepted beats only, which is 0 for a constant 1 on even beats.
- **Saturation.** COUNT_BITS=4 and 20 isolated pulses on beam 0 in one gate.
  - Required: bank[0]=15 and `rd_sat_o`=1.
  - The next gate, with 2 pulses, reads 2 and `rd_sat_o`=0.
- **Gate boundary.** A rise on the cycle where `gate_cnt_o`=999 and another where `gate_cnt_o`=0.
  - Required: the first counts in the closing bank and the second in the next window, giving 1 each.
- **Reset mid-gate.** 5 pulses, then `reset_i` asserted for 3 cycles at cycle 400.
  - Required: no `update_o` before cycle 1000 after reset release; all outputs 0 during and immediately after reset; the next bank excludes the 5 pre-reset pulses.

Source files
------------

// File: rtl/l1_trigger_scaler_rx.sv
// Receive side of the packed L1 trigger stream: unpacks per-beam trigger bits,
// counts rising edges per beam over a fixed gate window and latches a readout bank.
`timescale 1ns/1ps

module l1_trigger_scaler_rx #(
  parameter  int NBEAMS     = 2,
  parameter  int COUNT_BITS = 16,
  parameter  int GATE_LEN   = 1000,
  localparam int SEL_W      = (NBEAMS > 1) ? $clog2(NBEAMS) : 1,
  localparam int GC_W       = $clog2(GATE_LEN)
) (
  input  logic                  aclk,
  input  logic                  reset_i,
  input  logic [127:0]          trig_tdata,
  input  logic                  trig_tvalid,
  output logic                  trig_tready,
  input  logic [SEL_W-1:0]      rd_sel_i,
  output logic [COUNT_BITS-1:0] rd_data_o,
  output logic                  rd_sat_o,
  output logic                  update_o,
  output logic [GC_W-1:0]       gate_cnt_o
);

  logic                  accepted;
  logic                  gate_last;
  logic [NBEAMS-1:0]     trig;
  logic [NBEAMS-1:0]     prev;
  logic [NBEAMS-1:0]     rise;
  logic [NBEAMS-1:0]     sat;
  logic [NBEAMS-1:0]     sat_next;
  logic [NBEAMS-1:0]     bank_sat;
  logic [COUNT_BITS-1:0] cnt      [NBEAMS];
  logic [COUNT_BITS-1:0] cnt_next [NBEAMS];
  logic [COUNT_BITS-1:0] bank     [NBEAMS];

  // Only word 0 carries trigger bits; the rest of the beat is deliberately dropped.
  logic unused_tdata;
  assign unused_tdata = ^{trig_tdata[127:4+NBEAMS], trig_tdata[3:0]};

  assign trig_tready = ~reset_i;
  assign accepted    = trig_tvalid & trig_tready;
  assign trig        = trig_tdata[4 +: NBEAMS];
  assign rise        = {NBEAMS{accepted}} & trig & ~prev;
  assign gate_last   = (gate_cnt_o == GC_W'(GATE_LEN - 1));

  // Saturating increment; an attempt at full scale flags saturation instead.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    sat_next = sat;
    for (int b = 0; b < NBEAMS; b++) begin
      cnt_next[b] = cnt[b];
      if (rise[b]) begin
        if (&cnt[b]) sat_next[b] = 1'b1;
        else         cnt_next[b] = cnt[b] + COUNT_BITS'(1);
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (reset_i) begin
      // NOTE: the bank is a small register array, not RAM, so clearing it in reset is cheap and required.
      prev       <= '1;
      sat        <= '0;
      bank_sat   <= '0;
      update_o   <= 1'b0;
      gate_cnt_o <= '0;
      for (int b = 0; b < NBEAMS; b++) begin
        cnt[b]  <= '0;
        bank[b] <= '0;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all registers sample pre-edge values.
      gate_cnt_o <= gate_last ? '0 : gate_cnt_o + GC_W'(1);
      update_o   <= gate_last;
      if (accepted) prev <= trig;
      if (gate_last) begin
        bank_sat <= sat_next;
        sat      <= '0;
        for (int b = 0; b < NBEAMS; b++) begin
          bank[b] <= cnt_next[b];
          cnt[b]  <= '0;
        end
      end else begin
        sat <= sat_next;
        for (int b = 0; b < NBEAMS; b++) cnt[b] <= cnt_next[b];
      end
    end
  end

  // Registered readout; selections beyond the beam count read as zero.
  always_ff @(posedge aclk) begin
    if (reset_i) begin
      rd_data_o <= '0;
      rd_sat_o  <= 1'b0;
    end else if (int'(rd_sel_i) < NBEAMS) begin
      rd_data_o <= bank[rd_sel_i];
      rd_sat_o  <= bank_sat[rd_sel_i];
    end else begin
      rd_data_o <= '0;
      rd_sat_o  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_l1_trigger_scaler_rx.sv
// Directed bench for l1_trigger_scaler_rx: a 16-bit and a 4-bit instance share one
// stimulus stream; each gate is played from a per-position pattern table.
`timescale 1ns/1ps

module tb_l1_trigger_scaler_rx;

  localparam int GATE = 1000;

  logic         aclk = 1'b0;
  logic         reset_i = 1'b1;
  logic [127:0] trig_tdata = '0;
  logic         trig_tvalid = 1'b0;
  logic         rd_sel_i = 1'b0;

  logic         trig_tready, rd_sat, update, tready4, rd_sat4, update4;
  logic [15:0]  rd_data;
  logic [3:0]   rd_data4;
  logic [9:0]   gate_cnt, gate_cnt4;

  l1_trigger_scaler_rx #(.NBEAMS(2), .COUNT_BITS(16), .GATE_LEN(GATE)) dut (
    .aclk(aclk), .reset_i(reset_i), .trig_tdata(trig_tdata), .trig_tvalid(trig_tvalid),
    .trig_tready(trig_tready), .rd_sel_i(rd_sel_i), .rd_data_o(rd_data), .rd_sat_o(rd_sat),
    .update_o(update), .gate_cnt_o(gate_cnt));

  l1_trigger_scaler_rx #(.NBEAMS(2), .COUNT_BITS(4), .GATE_LEN(GATE)) dut4 (
    .aclk(aclk), .reset_i(reset_i), .trig_tdata(trig_tdata), .trig_tvalid(trig_tvalid),
    .trig_tready(tready4), .rd_sel_i(rd_sel_i), .rd_data_o(rd_data4), .rd_sat_o(rd_sat4),
    .update_o(update4), .gate_cnt_o(gate_cnt4));

  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0] pat_beams [GATE];
  logic       pat_valid [GATE];
  logic [1:0] idle_beams = 2'b00;

  int         upd_cnt;
  logic       cap_upd0, cap_upd1, cap_sat0, cap_sat1, cap4_sat0;
  logic [15:0] cap_rd0, cap_rd1;
  logic [3:0] cap4_rd0;
  logic [9:0] cap_gc0, cap_gc_last;

  // Unused payload bits are filled with ones so a DUT that looks at them misbehaves.
  function automatic logic [127:0] pack(input logic [1:0] beams);
    return {{7{16'hFFF0}}, 10'h3FF, beams, 4'h0};
  endfunction

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic clear_pattern();
    for (int g = 0; g < GATE; g++) begin
      pat_beams[g] = 2'b00;
      pat_valid[g] = 1'b1;
    end
  endtask

  task automatic do_reset(input logic [1:0] beams);
    reset_i     = 1'b1;
    trig_tvalid = 1'b1;
    trig_tdata  = pack(beams);
    repeat (3) tick();
    reset_i = 1'b0;
  endtask

  // Drives gate positions gs..ge from the pattern table.
  task automatic play_gate(input int gs, input int ge);
    upd_cnt = 0;
    for (int g = gs; g <= ge; g++) begin
      if (update) upd_cnt++;
      if (g == GATE - 1) cap_gc_last = gate_cnt;
      trig_tvalid = pat_valid[g];
      trig_tdata  = pack(pat_beams[g]);
      tick();
    end
  endtask

  // Consumes positions 0..2 of the next gate with idle input, capturing both bank entries.
  task automatic read_bank();
    trig_tvalid = 1'b1;
    trig_tdata  = pack(idle_beams);
    cap_upd0 = update;
    cap_gc0  = gate_cnt;
    rd_sel_i = 1'b0;
    tick();
    cap_upd1  = update;
    cap_rd0   = rd_data;
    cap_sat0  = rd_sat;
    cap4_rd0  = rd_data4;
    cap4_sat0 = rd_sat4;
    rd_sel_i  = 1'b1;
    tick();
    cap_rd1  = rd_data;
    cap_sat1 = rd_sat;
    rd_sel_i = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset_i     = 1'b1;
    trig_tvalid = 1'b1;
    trig_tdata  = pack(2'b00);
    rd_sel_i    = 1'b0;
    tick();
    tick();
    n_checks++; if (trig_tready !== 1'b0) begin n_fail++; $display("FAIL reset_tready: got %b want 0", trig_tready); end
    n_checks++; if (update !== 1'b0) begin n_fail++; $display("FAIL reset_update: got %b want 0", update); end
    n_checks++; if (rd_data !== 16'd0 || rd_sat !== 1'b0) begin n_fail++; $display("FAIL reset_rd: got %0d/%b want 0/0", rd_data, rd_sat); end
    n_checks++; if (gate_cnt !== 10'd0) begin n_fail++; $display("FAIL reset_gate_cnt: got %0d want 0", gate_cnt); end
    reset_i = 1'b0;
    #1;
    n_checks++; if (trig_tready !== 1'b1) begin n_fail++; $display("FAIL release_tready: got %b want 1", trig_tready); end
  endtask

  task automatic test_single_pulses();
    clear_pattern();
    pat_beams[10] = 2'b01;
    pat_beams[20] = 2'b01;
    pat_beams[30] = 2'b01;
    play_gate(0, GATE - 1);
    read_bank();
    n_checks++; if (upd_cnt != 0) begin n_fail++; $display("FAIL single_early_update: got %0d pulses want 0", upd_cnt); end
    n_checks++; if (cap_upd0 !== 1'b1) begin n_fail++; $display("FAIL single_update_at_1000: got %b want 1", cap_upd0); end
    n_checks++; if (cap_upd1 !== 1'b0) begin n_fail++; $display("FAIL single_update_width: got %b want 0", cap_upd1); end
    n_checks++; if (cap_gc_last !== 10'd999 || cap_gc0 !== 10'd0) begin n_fail++; $display("FAIL single_gate_cnt: got %0d,%0d want 999,0", cap_gc_last, cap_gc0); end
    n_checks++; if (cap_rd0 !== 16'd3 || cap_sat0 !== 1'b0) begin n_fail++; $display("FAIL single_bank0: got %0d/%b want 3/0", cap_rd0, cap_sat0); end
    n_checks++; if (cap_rd1 !== 16'd0 || cap_sat1 !== 1'b0) begin n_fail++; $display("FAIL single_bank1: got %0d/%b want 0/0", cap_rd1, cap_sat1); end
  endtask

  task automatic test_level_through_reset();
    do_reset(2'b01);
    clear_pattern();
    for (int g = 0; g < 500; g++) pat_beams[g] = 2'b01;
    play_gate(0, GATE - 1);
    read_bank();
    n_checks++; if (cap_rd0 !== 16'd0) begin n_fail++; $display("FAIL held_through_reset: got %0d want 0", cap_rd0); end
    clear_pattern();
    for (int g = 100; g <= 600; g++) pat_beams[g] = 2'b01;
    play_gate(3, GATE - 1);
    read_bank();
    n_checks++; if (cap_upd0 !== 1'b1) begin n_fail++; $display("FAIL held_update_period: got %b want 1", cap_upd0); end
    n_checks++; if (cap_rd0 !== 16'd1) begin n_fail++; $display("FAIL held_100_to_600: got %0d want 1", cap_rd0); end
  endtask

  task automatic test_tvalid_gaps();
    do_reset(2'b10);
    clear_pattern();
    for (int g = 0; g < GATE; g++) begin
      pat_valid[g] = (g % 2 == 0);
      pat_beams[g] = (g % 2 == 0) ? 2'b10 : 2'b00;
    end
    play_gate(0, GATE - 1);
    read_bank();
    n_checks++; if (cap_rd1 !== 16'd0) begin n_fail++; $display("FAIL gaps_constant_accepted: got %0d want 0", cap_rd1); end
    for (int g = 0; g < GATE; g++) begin
      pat_valid[g] = (g % 2 == 0);
      pat_beams[g] = (g % 2 == 1) ? 2'b10 : ((g % 4 == 0) ? 2'b10 : 2'b00);
    end
    play_gate(3, GATE - 1);
    read_bank();
    n_checks++; if (cap_rd1 !== 16'd249) begin n_fail++; $display("FAIL gaps_alternating: got %0d want 249", cap_rd1); end
    n_checks++; if (cap_rd0 !== 16'd0) begin n_fail++; $display("FAIL gaps_beam0_idle: got %0d want 0", cap_rd0); end
  endtask

  task automatic test_saturation();
    do_reset(2'b00);
    clear_pattern();
    for (int k = 1; k <= 20; k++) pat_beams[10 * k] = 2'b01;
    play_gate(0, GATE - 1);
    read_bank();
    n_checks++; if (cap4_rd0 !== 4'd15 || cap4_sat0 !== 1'b1) begin n_fail++; $display("FAIL sat_4bit: got %0d/%b want 15/1", cap4_rd0, cap4_sat0); end
    n_checks++; if (cap_rd0 !== 16'd20 || cap_sat0 !== 1'b0) begin n_fail++; $display("FAIL sat_16bit: got %0d/%b want 20/0", cap_rd0, cap_sat0); end
    clear_pattern();
    pat_beams[10] = 2'b01;
    pat_beams[20] = 2'b01;
    play_gate(3, GATE - 1);
    read_bank();
    n_checks++; if (cap4_rd0 !== 4'd2 || cap4_sat0 !== 1'b0) begin n_fail++; $display("FAIL sat_cleared: got %0d/%b want 2/0", cap4_rd0, cap4_sat0); end
  endtask

  task automatic test_gate_boundary();
    clear_pattern();
    pat_beams[GATE - 1] = 2'b01;
    idle_beams = 2'b10;
    play_gate(3, GATE - 1);
    read_bank();
    n_checks++; if (cap_gc_last !== 10'd999) begin n_fail++; $display("FAIL boundary_gate_cnt: got %0d want 999", cap_gc_last); end
    n_checks++; if (cap_rd0 !== 16'd1 || cap_rd1 !== 16'd0) begin n_fail++; $display("FAIL boundary_closing: got %0d,%0d want 1,0", cap_rd0, cap_rd1); end
    idle_beams = 2'b00;
    clear_pattern();
    play_gate(3, GATE - 1);
    read_bank();
    n_checks++; if (cap_rd0 !== 16'd0 || cap_rd1 !== 16'd1) begin n_fail++; $display("FAIL boundary_opening: got %0d,%0d want 0,1", cap_rd0, cap_rd1); end
  endtask

  task automatic test_reset_mid_gate();
    rd_sel_i = 1'b1;
    clear_pattern();
    for (int k = 0; k < 5; k++) pat_beams[100 + 10 * k] = 2'b01;
    play_gate(3, 399);
    n_checks++; if (rd_data !== 16'd1) begin n_fail++; $display("FAIL midreset_pre_read: got %0d want 1", rd_data); end
    reset_i     = 1'b1;
    trig_tvalid = 1'b1;
    trig_tdata  = pack(2'b00);
    tick();
    n_checks++; if (rd_data !== 16'd0 || update !== 1'b0 || gate_cnt !== 10'd0 || trig_tready !== 1'b0) begin
      n_fail++; $display("FAIL midreset_during: rd=%0d upd=%b gc=%0d rdy=%b want 0,0,0,0", rd_data, update, gate_cnt, trig_tready);
    end
    tick();
    tick();
    reset_i = 1'b0;
    #1;
    n_checks++; if (rd_data !== 16'd0 || rd_sat !== 1'b0 || update !== 1'b0 || gate_cnt !== 10'd0) begin
      n_fail++; $display("FAIL midreset_after: rd=%0d sat=%b upd=%b gc=%0d want 0,0,0,0", rd_data, rd_sat, update, gate_cnt);
    end
    rd_sel_i = 1'b0;
    clear_pattern();
    pat_beams[50] = 2'b01;
    pat_beams[60] = 2'b01;
    play_gate(0, GATE - 1);
    read_bank();
    n_checks++; if (upd_cnt != 0) begin n_fail++; $display("FAIL midreset_early_update: got %0d pulses want 0", upd_cnt); end
    n_checks++; if (cap_upd0 !== 1'b1) begin n_fail++; $display("FAIL midreset_update: got %b want 1", cap_upd0); end
    n_checks++; if (cap_rd0 !== 16'd2) begin n_fail++; $display("FAIL midreset_bank0: got %0d want 2", cap_rd0); end
  endtask

  initial begin
    test_reset();
    test_single_pulses();
    test_level_through_reset();
    test_tvalid_gaps();
    test_saturation();
    test_gate_boundary();
    test_reset_mid_gate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
